seg7_glyph_reader: RTL and testbench
====================================

Name: seg7_glyph_reader

Overview:
- Reader end of the 7-segment interface: samples a 7-bit segment bus, such as the output of the hex-to-7-segment decoder, and recovers the hex digit it shows.
- Requires a pattern to be held for STABLE_CYCLES clocks before accepting it; filters glitches.
- Suppresses repeats of the same glyph.
- Presents each accepted digit on a one-entry valid/ready output.
- Used as an on-chip loopback checker for the decoder and as a bench monitor.

Parameters:
STABLE_CYCLES, 4, consecutive unchanged samples needed to qualify a pattern; legal range 1..255
ACTIVE_LOW, 0, 1 = seg is active-low (inverted at input before any other logic)

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
seg  input  7  segment bus, bit0 = a ... bit6 = g
out_ready  input  1  consumer accepts out_* this cycle when out_valid=1
out_valid  output  1  out_digit/out_error hold an unconsumed report
out_digit  output  4  decoded hex value; 0 when out_error=1
out_error  output  1  reported pattern is not a legal hex glyph
overrun  output  1  sticky: a report was dropped because the output slot was full
stable  output  1  current pattern has been stable for STABLE_CYCLES
digit_count  output  8  number of reports loaded into the output slot; wraps 255->0

Behaviour:
- Reset state (synchronous): seg_q=0, cnt=0, last_valid=0, out_valid=0, out_digit=0, out_error=0, overrun=0, digit_count=0. stable=0 follows from cnt=0.
- Reset asserted mid-operation clears a pending report; no handshake completes in that cycle.
- s_in = ACTIVE_LOW ? ~seg : seg.
- Stability counter (cnt, 8 bits):
  - If s_in != seg_q: seg_q<=s_in, cnt<=0.
  - Otherwise cnt<=cnt+1, saturating at STABLE_CYCLES.
  - stable = (cnt == STABLE_CYCLES).
- Qualify event: the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. It fires once per stable period.
- Latency: pattern first captured into seg_q at edge E0 and held -> qualify at edge E0+STABLE_CYCLES.
- After reset, seg_q=0 counts as captured at the reset edge.
- Any change before qualify restarts the count; no report is made for glitches.
- On qualify:
  - seg_q==0 (blank): no report; last_valid<=0. The same digit is reported again after a blank.
  - last_valid && seg_q==last_pat: no report (dedup).
  - Otherwise, report.
- Report, when the slot is free (out_valid==0, or out_valid && out_ready in the same cycle):
  - Load out_digit/out_error from the glyph table; out_valid<=1.
  - digit_count<=digit_count+1.
  - last_pat<=seg_q; last_valid<=1.
- Report, when the slot is full (out_valid && !out_ready): pattern dropped, overrun<=1; last_pat/last_valid unchanged.
- Glyph table (g..a hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other nonzero pattern: out_error=1, out_digit=0. It still counts, still dedups and is still acknowledged like a digit.
- Handshake:
  - While out_valid=1 && out_ready=0, out_digit/out_error must not change.
  - out_valid&&out_ready with no simultaneous load: out_valid<=0 next edge.
  - Accept and load in the same edge: out_valid stays 1 with the new data.
  - out_ready while out_valid=0 is ignored.
- overrun clears only on reset.
- digit_count wraps 255->0 with no flag.
- STABLE_CYCLES=1: qualify on the first edge after capture.

Test Plan:
- Reset, seg=7'h4F held, out_ready=1, STABLE_CYCLES=4 -> after 5 edges out_valid=1, out_digit=3, out_error=0, digit_count=1; accepted next edge, out_valid=0.
- 4F held, then 06 for 2 cycles, then back to 4F for 10 cycles -> only one report (digit 3); no report for 06 (glitch); no second 3 (dedup).
- 5B stable, then 00 stable, then 5B stable, out_ready=1 -> two reports of digit 2, digit_count=2; blank not reported.
- out_ready=0; present 3F then 06, each stable -> out_valid=1, out_digit=0 held; 06 dropped, overrun=1; release ready -> single accept, digit_count=1.
- 7'h49 stable -> out_valid=1, out_error=1, out_digit=0. ACTIVE_LOW=1 with seg=~7'h71 -> out_digit=F.
- Report pending (out_valid=1), reset pulsed for 1 cycle -> next edge all outputs 0, overrun=0; 256 distinct reports -> digit_count wraps to 0.

Source files
------------

// File: rtl/seg7_glyph_reader.sv
// seg7_glyph_reader: recovers hex digits from a 7-segment bus with glitch filtering, dedup and a one-entry valid/ready slot
module seg7_glyph_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_error,
    output logic       overrun,
    output logic       stable,
    output logic [7:0] digit_count
);
    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    logic [6:0] s_in, seg_q, last_pat;
    logic [7:0] cnt;
    logic       last_valid, qualify, report, slot_free, load, g_err;
    logic [3:0] g_digit;

    assign s_in      = ACTIVE_LOW ? ~seg : seg;
    assign stable    = cnt == SC;
    assign qualify   = (s_in == seg_q) && (cnt == SC - 8'd1);
    assign report    = qualify && seg_q != 7'h00 && !(last_valid && seg_q == last_pat);
    assign slot_free = !out_valid || out_ready;
    assign load      = report && slot_free;

    // glyph table lookup; anything not in the table is flagged as an error with digit 0
    always_comb begin
        {g_err, g_digit} = 5'h10;
        case (seg_q)
            7'h3F: {g_err, g_digit} = 5'h00;
            7'h06: {g_err, g_digit} = 5'h01;
            7'h5B: {g_err, g_digit} = 5'h02;
            7'h4F: {g_err, g_digit} = 5'h03;
            7'h66: {g_err, g_digit} = 5'h04;
            7'h6D: {g_err, g_digit} = 5'h05;
            7'h7D: {g_err, g_digit} = 5'h06;
            7'h07: {g_err, g_digit} = 5'h07;
            7'h7F: {g_err, g_digit} = 5'h08;
            7'h6F: {g_err, g_digit} = 5'h09;
            7'h77: {g_err, g_digit} = 5'h0A;
            7'h7C: {g_err, g_digit} = 5'h0B;
            7'h39: {g_err, g_digit} = 5'h0C;
            7'h5E: {g_err, g_digit} = 5'h0D;
            7'h79: {g_err, g_digit} = 5'h0E;
            7'h71: {g_err, g_digit} = 5'h0F;
            default: {g_err, g_digit} = 5'h10;
        endcase
    end

    // stability counter, dedup memory and the output slot
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= '0;
            cnt         <= '0;
            last_pat    <= '0;
            last_valid  <= 1'b0;
            out_valid   <= 1'b0;
            out_digit   <= '0;
            out_error   <= 1'b0;
            overrun     <= 1'b0;
            digit_count <= '0;
        end else begin
            if (s_in != seg_q) begin
                seg_q <= s_in;
                cnt   <= '0;
            end else if (cnt != SC) begin
                cnt <= cnt + 8'd1;
            end
            if (qualify && seg_q == 7'h00) last_valid <= 1'b0;
            if (load) begin
                out_valid   <= 1'b1;
                out_digit   <= g_digit;
                out_error   <= g_err;
                digit_count <= digit_count + 8'd1;
                last_pat    <= seg_q;
                last_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (report && !slot_free) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg7_glyph_reader.sv
// tb_seg7_glyph_reader: directed scoreboard bench for the 7-segment reader
module tb_seg7_glyph_reader;
    logic       clk = 1'b0, reset = 1'b1, out_ready = 1'b1;
    logic [6:0] seg = 7'h00;
    logic       out_valid, out_error, overrun, stable;
    logic [3:0] out_digit;
    logic [7:0] digit_count;
    logic [6:0] seg2 = 7'h7F;
    logic       out_valid2, out_error2, overrun2, stable2;
    logic [3:0] out_digit2;
    logic [7:0] digit_count2;
    int tests = 0, fails = 0;
    logic [4:0] sb[$];
    logic [6:0] glyphs[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_glyph_reader dut (
        .clk(clk), .reset(reset), .seg(seg), .out_ready(out_ready),
        .out_valid(out_valid), .out_digit(out_digit), .out_error(out_error),
        .overrun(overrun), .stable(stable), .digit_count(digit_count)
    );

    seg7_glyph_reader #(.STABLE_CYCLES(1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .seg(seg2), .out_ready(1'b1),
        .out_valid(out_valid2), .out_digit(out_digit2), .out_error(out_error2),
        .overrun(overrun2), .stable(stable2), .digit_count(digit_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyphs[i] == p) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every completed handshake must match the oldest expected report
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_report", {27'd0, out_error, out_digit}, 32'hFFFF);
            else chk("sb_report", {27'd0, out_error, out_digit}, {27'd0, sb.pop_front()});
        end
    end

    initial begin
        step(1);
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_error", out_error, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_stable", stable, 0);
        seg = 7'h4F; sb.push_back(model(7'h4F));
        step(4);
        chk("lat_early", out_valid, 0);
        step(1);
        chk("lat_valid", out_valid, 1);
        chk("lat_digit", out_digit, 3);
        chk("lat_count", digit_count, 1);
        step(1);
        chk("lat_accept", out_valid, 0);
        seg = 7'h06; step(2);
        seg = 7'h4F; step(10);
        chk("glitch_count", digit_count, 1);
        chk("glitch_stable", stable, 1);
        seg = 7'h5B; sb.push_back(model(7'h5B)); step(6);
        seg = 7'h00; step(6);
        seg = 7'h5B; sb.push_back(model(7'h5B)); step(6);
        chk("blank_count", digit_count, 3);
        out_ready = 1'b0;
        seg = 7'h3F; sb.push_back(model(7'h3F)); step(6);
        seg = 7'h06; step(6);
        chk("full_valid", out_valid, 1);
        chk("full_digit", out_digit, 0);
        chk("full_overrun", overrun, 1);
        chk("full_count", digit_count, 4);
        out_ready = 1'b1; step(1);
        chk("full_release", out_valid, 0);
        chk("full_count2", digit_count, 4);
        seg = 7'h49; sb.push_back(model(7'h49)); step(5);
        chk("err_valid", out_valid, 1);
        chk("err_flag", out_error, 1);
        chk("err_digit", out_digit, 0);
        step(1);
        out_ready = 1'b0;
        seg = 7'h7F; step(6);
        chk("pend_valid", out_valid, 1);
        chk("pend_digit", out_digit, 8);
        out_ready = 1'b1; reset = 1'b1; step(1);
        reset = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_digit", out_digit, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_count", digit_count, 0);
        for (int i = 0; i < 256; i++) begin
            seg = glyphs[i % 16]; sb.push_back(model(glyphs[i % 16])); step(5);
            if (i == 254) chk("wrap_255", digit_count, 255);
        end
        chk("wrap_0", digit_count, 0);
        step(1);
        seg2 = ~7'h71; step(1);
        chk("al_capture", out_valid2, 0);
        step(1);
        chk("al_valid", out_valid2, 1);
        chk("al_digit", out_digit2, 4'hF);
        chk("al_stable", stable2, 1);
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
